// File: rtl/viterbi_aes_pkg.sv
// Shared encodings and helpers for the viterbi/aes stress harness.
package viterbi_aes_pkg;

   typedef enum logic [1:0] {
      MODE_AND    = 2'b00,
      MODE_OR     = 2'b01,
      MODE_XOR    = 2'b10,
      MODE_FREEZE = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2
   } state_e;

   // Number of decoder slices needed to build a 128-bit key.
   function automatic int fill_cyc(input int num_ch);
      return 128 / num_ch;
   endfunction

endpackage

// File: rtl/aes128.sv
// Latency-accurate cipher stand-in: free-running LAT-deep pipeline, no reset, no handshake.
module aes128 #(
   parameter int LAT = 21
) (
   input  logic         clk,
   input  logic [127:0] state,
   input  logic [127:0] key,
   output logic [127:0] out
);

   logic [LAT-1:0][127:0] pipe;
   logic [127:0]          mix;

   assign mix = key ^ state;

   always_ff @(posedge clk) begin
      pipe[0] <= {mix[119:0], mix[127:120]};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end

   assign out = pipe[LAT-1];

endmodule

// File: rtl/viterbi_aes_harness_aes_out_reduce.sv
// Combinational 128 -> OUT_W reducer; each output bit folds one contiguous group.
module aes_out_reduce
   import viterbi_aes_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic [127:0]     data,
   input  mode_e            mode,
   output logic [OUT_W-1:0] red
);

   localparam int GRP = 128 / OUT_W;

   for (genvar g = 0; g < OUT_W; g++) begin : g_grp
      wire [GRP-1:0] grp = data[GRP*g +: GRP];
      // FREEZE falls through to XOR; the harness never registers it.
      assign red[g] = (mode == MODE_AND) ? &grp :
                      (mode == MODE_OR)  ? |grp : ^grp;
   end

endmodule

// File: rtl/viterbi_tx_rx.sv
// Behavioural channel stand-in: one registered decoder bit per cycle, cleared by rst.
module viterbi_tx_rx (
   input  logic clk,
   input  logic rst,
   input  logic enable_encoder_i,
   input  logic encoder_i,
   output logic decoder_o
);

   always_ff @(posedge clk) begin
      if (rst) decoder_o <= 1'b0;
      else     decoder_o <= encoder_i ^ enable_encoder_i;
   end

endmodule

// File: rtl/viterbi_aes_harness.sv
// Ring of decoder channels fills an AES key; FSM waits out cipher latency and captures a reduction.
module viterbi_aes_harness
   import viterbi_aes_pkg::*;
#(
   parameter int           NUM_CH     = 16,
   parameter int           OUT_W      = 16,
   parameter int           AES_LAT    = 21,
   parameter logic [127:0] STATE_INIT = 128'h0123456789ABCDEF
) (
   input  logic              clk_o,
   input  logic              rst_o,
   input  logic [NUM_CH-1:0] userInput_o,
   input  logic              enable_o,
   input  logic [1:0]        modeSel_o,
   output logic [OUT_W-1:0]  designOutput_i,
   output logic              outValid_i,
   output logic [15:0]       jobCount_i
);

   localparam int FILL_CYC = fill_cyc(NUM_CH);

   logic [NUM_CH-1:0] dec;
   logic [NUM_CH-1:0] dec_slice;
   logic [127:0]      key_sr, key_q, key_next, aes_out;
   logic [OUT_W-1:0]  red;
   logic [7:0]        fill_cnt;
   logic [15:0]       wait_cnt;
   state_e            state;

   // Skip-one ring: channel k listens to channel k-2; dec[0] lands in the slice MSB.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      viterbi_tx_rx u_ch (
         .clk              (clk_o),
         .rst              (rst_o),
         .enable_encoder_i (userInput_o[k]),
         .encoder_i        (dec[(k + NUM_CH - 2) % NUM_CH]),
         .decoder_o        (dec[k])
      );
      assign dec_slice[NUM_CH-1-k] = dec[k];
   end

   assign key_next = {key_sr[127-NUM_CH:0], dec_slice};

   aes128 #(.LAT(AES_LAT)) u_aes (
      .clk   (clk_o),
      .state (STATE_INIT),
      .key   (key_q),
      .out   (aes_out)
   );

   aes_out_reduce #(.OUT_W(OUT_W)) u_red (
      .data (aes_out),
      .mode (mode_e'(modeSel_o)),
      .red  (red)
   );

   always_ff @(posedge clk_o) begin
      if (rst_o) begin
         state          <= FILL;
         key_sr         <= '0;
         key_q          <= '0;
         fill_cnt       <= '0;
         wait_cnt       <= '0;
         designOutput_i <= '0;
         outValid_i     <= 1'b0;
         jobCount_i     <= '0;
      end else begin
         outValid_i <= 1'b0;
         case (state)
            FILL: if (enable_o) begin
               key_sr <= key_next;
               if (fill_cnt == 8'(FILL_CYC - 1)) begin
                  key_q    <= key_next;
                  fill_cnt <= '0;
                  wait_cnt <= '0;
                  state    <= WAIT;
               end else begin
                  fill_cnt <= fill_cnt + 8'd1;
               end
            end
            // key_q is held steady until the cipher output reflects it.
            WAIT: begin
               wait_cnt <= wait_cnt + 16'd1;
               if (wait_cnt == 16'(AES_LAT - 1)) state <= CAPTURE;
            end
            CAPTURE: begin
               if (mode_e'(modeSel_o) != MODE_FREEZE) begin
                  designOutput_i <= red;
                  outValid_i     <= 1'b1;
               end
               jobCount_i <= jobCount_i + 16'd1;
               state      <= FILL;
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_aes_harness.sv
// Directed bench: pulse timing, reduced ciphertext, stalls, freeze, mid-job reset, small config wrap.
module tb_viterbi_aes_harness;

   localparam logic [127:0] ST = 128'h0123456789ABCDEF;

   logic        clk = 1'b0;
   logic        rst, en, rst4, en4, ov, ov4;
   logic [15:0] ui, dout, jc, jc4, prev;
   logic [3:0]  ui4;
   logic [1:0]  mode, mode4;
   logic [7:0]  dout4;
   int          compared = 0, mismatched = 0, cyc = 0, base = 0, base4 = 0, at;
   bit          seen;

   always #5 clk = ~clk;

   viterbi_aes_harness u16 (
      .clk_o(clk), .rst_o(rst), .userInput_o(ui), .enable_o(en), .modeSel_o(mode),
      .designOutput_i(dout), .outValid_i(ov), .jobCount_i(jc)
   );

   viterbi_aes_harness #(.NUM_CH(4), .OUT_W(8), .AES_LAT(5)) u4 (
      .clk_o(clk), .rst_o(rst4), .userInput_o(ui4), .enable_o(en4), .modeSel_o(mode4),
      .designOutput_i(dout4), .outValid_i(ov4), .jobCount_i(jc4)
   );

   function automatic logic [31:0] ring_step(input logic [31:0] d, input logic [31:0] u, input int n);
      logic [31:0] nd = '0;
      for (int k = 0; k < n; k++) nd[k] = d[(k + n - 2) % n] ^ u[k];
      return nd;
   endfunction

   // Key built from ring states t0 .. t0+128/n-1 (t counted in edges since the reset edge).
   function automatic logic [127:0] key_for(input int t0, input logic [31:0] u, input int n);
      logic [31:0]  d   = '0;
      logic [127:0] key = '0;
      for (int t = 0; t < t0; t++) d = ring_step(d, u, n);
      for (int i = 0; i < 128 / n; i++) begin
         key = key << n;
         for (int k = 0; k < n; k++) key[n-1-k] = d[k];
         d = ring_step(d, u, n);
      end
      return key;
   endfunction

   function automatic logic [127:0] cipher(input logic [127:0] key);
      logic [127:0] x = key ^ ST;
      return {x[119:0], x[127:120]};
   endfunction

   function automatic logic [15:0] reduce(input logic [1:0] m, input logic [127:0] v, input int outw);
      logic [15:0] r = '0;
      int grp = 128 / outw;
      for (int g = 0; g < outw; g++) begin
         logic a = 1'b1, o = 1'b0, x = 1'b0;
         for (int b = 0; b < grp; b++) begin
            a &= v[g*grp + b]; o |= v[g*grp + b]; x ^= v[g*grp + b];
         end
         r[g] = (m == 2'b00) ? a : (m == 2'b01) ? o : x;
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1; cyc++;
   endtask

   task automatic wait_pulse(input bit sel, input int budget, output int got);
      got = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if ((sel ? ov4 : ov) === 1'b1) begin got = cyc; break; end
      end
   endtask

   // s = edge after which the job's first fill shift samples the ring.
   task automatic job(input bit sel, input string tag, input int exp_at, input int s,
                      input logic [1:0] m, input int jobs);
      wait_pulse(sel, exp_at - cyc + 5, at);
      check({tag, "_cycle"}, at, exp_at);
      if (sel) begin
         check({tag, "_data"}, dout4, reduce(m, cipher(key_for(s - base4, 32'h6, 4)), 8));
         check({tag, "_jobs"}, jc4, jobs);
      end else begin
         check({tag, "_data"}, dout, reduce(m, cipher(key_for(s - base, 32'hA5A5, 16)), 16));
         check({tag, "_jobs"}, jc, jobs);
      end
   endtask

   initial begin
      rst = 1'b1; rst4 = 1'b1; ui4 = 4'h6; en4 = 1'b1; mode4 = 2'b10;
      ui = 16'h0; en = 1'b0; mode = 2'b00;

      // Reset held with random stimulus.
      for (int i = 0; i < 3; i++) begin
         ui = 16'($urandom); en = 1'($urandom_range(0, 1)); mode = 2'($urandom_range(0, 3));
         tick();
         check("rst_dout", dout, 0);
         check("rst_valid", ov, 0);
         check("rst_jobs", jc, 0);
      end
      ui = 16'hA5A5; en = 1'b1; mode = 2'b10; rst = 1'b0; cyc = 0; base = 0;

      job(0, "j1", 30, 0, 2'b10, 1);
      job(0, "j2", 60, 30, 2'b10, 2);
      job(0, "j3", 90, 60, 2'b10, 3);

      // Stall inside FILL delays the job.
      en = 1'b0;
      tick();
      check("j3_single", ov, 0);
      repeat (4) tick();
      en = 1'b1;
      job(0, "fill_stall", 125, 95, 2'b10, 4);

      // Stall inside WAIT has no effect.
      while (cyc < 135) tick();
      en = 1'b0;
      repeat (5) tick();
      en = 1'b1;
      job(0, "wait_stall", 155, 125, 2'b10, 5);

      // FREEZE: no pulse, output held, job still counted.
      prev = dout; mode = 2'b11; seen = 1'b0;
      while (cyc < 185) begin
         tick();
         if (ov === 1'b1) seen = 1'b1;
      end
      check("freeze_pulse", seen, 0);
      check("freeze_hold", dout, prev);
      check("freeze_jobs", jc, 6);
      mode = 2'b10;

      // Mode glitch outside CAPTURE is ignored.
      while (cyc < 200) tick();
      mode = 2'b11;
      tick();
      mode = 2'b10;
      job(0, "mode_glitch", 215, 185, 2'b10, 7);

      mode = 2'b00;
      job(0, "and", 245, 215, 2'b00, 8);
      mode = 2'b01;
      job(0, "or", 275, 245, 2'b01, 9);
      mode = 2'b10;

      // Reset during WAIT at wait_cnt 10.
      while (cyc < 293) tick();
      rst = 1'b1;
      tick();
      check("midrst_dout", dout, 0);
      check("midrst_valid", ov, 0);
      check("midrst_jobs", jc, 0);
      rst = 1'b0; base = cyc;
      job(0, "after_rst", base + 30, base, 2'b10, 1);

      // Small configuration with jobCount wrap.
      rst4 = 1'b0; base4 = cyc;
      repeat (2) tick();
      force u4.jobCount_i = 16'hFFFF;
      tick();
      release u4.jobCount_i;
      tick();
      check("n4_preload", jc4, 16'hFFFF);
      job(1, "n4_j1", base4 + 38, base4, 2'b10, 0);
      job(1, "n4_j2", base4 + 76, base4 + 38, 2'b10, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
